data_cache: RTL and testbench
=============================

// Module: data_cache
// PURPOSE
// - Direct-mapped, write-through, no-write-allocate data cache between the execute/memory stage and dataMemory-class backing store.
// - Produces CD (hit data), CH (hit) and CV (line valid) toward the datapath.
// - On a read miss it fetches the aligned word over a req/ack handshake and stalls the pipeline.
// - Every store is forwarded to memory; a store hit also updates the cached word.
// PARAMETERS
// DATA_WIDTH  32  data/address width; only 32 is supported
// SET_BITS    3   index bits; 2^SET_BITS one-word lines
// PORTS
// clk         in   1   clock
// rst         in   1   synchronous active-high reset
// A           in   32  byte address from ALU
// WD          in   32  store data (LSB-justified)
// WE          in   1   store request
// RE          in   1   load request
// funct3      in   3   000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu (stores: 000 sb, 001 sh, 010 sw)
// CD          out  32  extended load data; valid when CH=1
// CH          out  1   hit: RE & CV & tag match & state==IDLE
// CV          out  1   valid bit of the line indexed by A
// stall       out  1   freeze the pipeline
// mem_req     out  1   memory request; held until mem_ack
// mem_we      out  1   1 = write, 0 = read
// mem_addr    out  32  reads: {A[31:2],2'b00}; writes: A
// mem_wd      out  32  write data (= WD)
// mem_funct3  out  3   reads: 010; writes: funct3
// mem_rdata   in   32  fill word; valid with mem_ack
// mem_ack     in   1   one-cycle completion pulse
// BEHAVIOUR
// - Address split: index = A[SET_BITS+1:2]; tag = A[31:SET_BITS+2]; byte offset = A[1:0].
// - Reset: all valid bits 0, state IDLE; mem_req, mem_we, stall and CH are 0.
//   - Tag/data arrays are not reset.
//   - CV reads 0 for every index until that line is filled.
// - Lookup is combinational in IDLE.
//   - Load extraction uses the byte/half selected by A[1:0].
//   - lh/lhu use A[1] and ignore A[0]; lw ignores A[1:0].
//   - Sign or zero extension follows funct3.
//   - funct3 011/110/111 on a load: CD = 0, CH forced 0, no miss action.
// - FSM states: IDLE, FILL, WBACK.
//   - IDLE, WE=1 -> WBACK. WE has priority if RE=1 in the same cycle.
//   - IDLE, RE & ~hit -> FILL.
//   - Otherwise stay in IDLE.
// - FILL:
//   - Drive mem_req=1, mem_we=0, stall=1.
//   - On mem_ack: write mem_rdata into data[index], write the tag, set valid, go to IDLE.
//   - The load is re-looked-up in the next cycle and hits (fill-to-hit latency = ack + 1).
// - WBACK:
//   - Drive mem_req=1, mem_we=1, stall=1.
//   - On mem_ack: if the line was valid with a matching tag, merge the WD bytes per funct3 and offset into the line; go to IDLE.
//   - Store misses leave the cache untouched (no allocate).
// - Request signals and stall are registered state decodes.
//   - mem_req rises in the cycle after the miss or store is detected.
//   - mem_req falls in the cycle after mem_ack.
// - stall is also 1, combinationally, in IDLE when a read miss or store is detected, so the instruction is held from cycle 0.
// - mem_ack in IDLE is ignored.
// - A, WD, funct3, WE and RE are stable while stall=1; the block does not capture them.
// - Reset mid-FILL or mid-WBACK abandons the transaction: no array update, and mem_req=0 the next cycle.
// - A multi-cycle mem_ack delay is legal; any latency of 1..N cycles works.
// - Index aliasing: a fill overwrites the line's previous tag unconditionally.
// STRUCTURE
// - Shared package cache_pkg holds:
//   - state enum {IDLE, FILL, WBACK};
//   - funct3 load/store constants (LB, LH, LW, LBU, LHU, SB, SH, SW);
//   - a function computing tag/index widths from SET_BITS.
// - One sub-module, load_extend: (word, offset, funct3) -> extended 32-bit result.
//   - Purely combinational; reusable by the memory module.
// - Arrays valid[], tag[], data[] are plain regs inside data_cache.
// TESTING
// - After reset: RE=1, lw, A=0x40 -> CV=0, CH=0, stall=1; mem_req=1, mem_addr=0x40 next cycle.
//   Then mem_ack with rdata=0xDEADBEEF -> CH=1, CD=0xDEADBEEF one cycle later.
// - Line holds 0x80FF7F01 at A=0x40:
//   - lb  A=0x41 -> CD=0x0000007F
//   - lb  A=0x43 -> CD=0xFFFFFF80
//   - lhu A=0x42 -> CD=0x000080FF
//   - lh  A=0x42 -> CD=0xFFFF80FF
//   All four are hits with no stall.
// - Store hit: sb A=0x42, WD=0x000000AA -> mem_we=1, mem_funct3=000.
//   After ack, lw 0x40 hits with CD=0x80AA7F01.
// - Store miss, sw A=0x100 -> memory write only; lw 0x100 then misses (CV=0).
// - Index conflict with SET_BITS=3: fill 0x40, then lw 0x60 -> miss, fill.
//   lw 0x40 afterwards misses again.
// - Assert rst during FILL with mem_ack withheld -> mem_req=0 next cycle, CV=0 for all indices.
//   A later mem_ack is ignored.
// - RE=1 and WE=1 together -> WBACK path taken; no fill is issued.

Source files
------------

// File: rtl/cache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_pkg : shared types and constants for the data cache             |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WBACK = 2'd2
  } state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  function automatic int index_bits(input int set_bits);
    return set_bits;
  endfunction

  // Tag covers everything above the index and the 2-bit byte offset.
  function automatic int tag_bits(input int set_bits);
    return 32 - set_bits - 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_extend : byte/half/word select with sign or zero extension       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module load_extend
  import cache_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = word_i[7:0];
    case (offset_i)
      2'd0: w_byte = word_i[7:0];
      2'd1: w_byte = word_i[15:8];
      2'd2: w_byte = word_i[23:16];
      2'd3: w_byte = word_i[31:24];
      default: w_byte = word_i[7:0];
    endcase
    w_half = offset_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    result_o = 32'd0;
    case (funct3_i)
      LB:  result_o = {{24{w_byte[7]}}, w_byte};
      LBU: result_o = {24'd0, w_byte};
      LH:  result_o = {{16{w_half[15]}}, w_half};
      LHU: result_o = {16'd0, w_half};
      LW:  result_o = word_i;
      default: result_o = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_cache.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_cache : direct-mapped, write-through, no-write-allocate D-cache  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module data_cache
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SET_BITS   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] WD,
  input  logic                  WE,
  input  logic                  RE,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] CD,
  output logic                  CH,
  output logic                  CV,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  localparam int IDX_W = index_bits(SET_BITS);
  localparam int TAG_W = tag_bits(SET_BITS);
  localparam int SETS  = 1 << IDX_W;

  state_e                  state_q;
  logic                    mem_req_q;
  logic                    mem_we_q;
  logic                    stall_q;
  logic [SETS-1:0]         valid_q;
  logic [TAG_W-1:0]        tag_q  [SETS];
  logic [DATA_WIDTH-1:0]   data_q [SETS];

  logic [IDX_W-1:0]        w_index;
  logic [TAG_W-1:0]        w_tag;
  logic                    w_line_hit;
  logic                    w_load_ok;
  logic                    w_read_miss;
  logic [DATA_WIDTH-1:0]   w_ext;
  logic [DATA_WIDTH-1:0]   w_merged;

  assign w_index    = A[IDX_W+1:2];
  assign w_tag      = A[DATA_WIDTH-1:IDX_W+2];
  assign CV         = valid_q[w_index];
  assign w_line_hit = CV && (tag_q[w_index] == w_tag);
  assign w_load_ok  = (funct3 == LB) || (funct3 == LH) || (funct3 == LW) ||
                      (funct3 == LBU) || (funct3 == LHU);
  // A store in the same cycle takes priority, so it masks the read miss.
  assign w_read_miss = RE && !WE && w_load_ok && !w_line_hit;

  load_extend u_load_extend (
    .word_i   (data_q[w_index]),
    .offset_i (A[1:0]),
    .funct3_i (funct3),
    .result_o (w_ext)
  );

  assign CD = w_load_ok ? w_ext : '0;
  assign CH = RE && w_load_ok && w_line_hit && (state_q == IDLE);

  assign stall      = stall_q || ((state_q == IDLE) && (WE || w_read_miss));
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_we_q ? A : {A[DATA_WIDTH-1:2], 2'b00};
  assign mem_wd     = WD;
  assign mem_funct3 = mem_we_q ? funct3 : LW;

  always_comb begin
    w_merged = data_q[w_index];
    case (funct3)
      SB: begin
        case (A[1:0])
          2'd0: w_merged[7:0]   = WD[7:0];
          2'd1: w_merged[15:8]  = WD[7:0];
          2'd2: w_merged[23:16] = WD[7:0];
          2'd3: w_merged[31:24] = WD[7:0];
          default: w_merged[7:0] = WD[7:0];
        endcase
      end
      SH: begin
        if (A[1]) w_merged[31:16] = WD[15:0];
        else      w_merged[15:0]  = WD[15:0];
      end
      SW: w_merged = WD;
      default: w_merged = data_q[w_index];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      stall_q   <= 1'b0;
      valid_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (WE) begin
            state_q   <= WBACK;
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b1;
            stall_q   <= 1'b1;
          end else if (w_read_miss) begin
            state_q   <= FILL;
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b0;
            stall_q   <= 1'b1;
          end
        end
        FILL: begin
          if (mem_ack) begin
            state_q          <= IDLE;
            mem_req_q        <= 1'b0;
            stall_q          <= 1'b0;
            valid_q[w_index] <= 1'b1;
          end
        end
        WBACK: begin
          if (mem_ack) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            stall_q   <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
          stall_q   <= 1'b0;
        end
      endcase
    end
  end

  // Tag/data arrays carry no reset; rst only blocks a coincident update.
  always_ff @(posedge clk) begin
    if (!rst && mem_ack) begin
      if (state_q == FILL) begin
        data_q[w_index] <= mem_rdata;
        tag_q[w_index]  <= w_tag;
      end else if ((state_q == WBACK) && w_line_hit) begin
        data_q[w_index] <= w_merged;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_data_cache : directed self-checking bench for data_cache           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] A, WD, CD, mem_addr, mem_wd, mem_rdata;
  logic        WE, RE, CH, CV, stall, mem_req, mem_we, mem_ack;
  logic [2:0]  funct3, mem_funct3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_cache #(.DATA_WIDTH(32), .SET_BITS(3)) dut (
    .clk(clk), .rst(rst), .A(A), .WD(WD), .WE(WE), .RE(RE), .funct3(funct3),
    .CD(CD), .CH(CH), .CV(CV), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_hit(input string tag, input logic [31:0] addr,
                          input logic [2:0] f3, input logic [31:0] exp);
    @(negedge clk);
    A = addr; funct3 = f3; RE = 1'b1; WE = 1'b0;
    #1;
    chk({tag, "_CH"}, {31'd0, CH}, 32'd1);
    chk({tag, "_CD"}, CD, exp);
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
  endtask

  task automatic miss_fill(input string tag, input logic [31:0] addr, input logic [31:0] rdata);
    @(negedge clk);
    A = addr; funct3 = 3'b010; RE = 1'b1; WE = 1'b0;
    #1;
    chk({tag, "_missCH"}, {31'd0, CH}, 32'd0);
    chk({tag, "_missStall"}, {31'd0, stall}, 32'd1);
    @(negedge clk); #1;
    chk({tag, "_req"}, {31'd0, mem_req}, 32'd1);
    chk({tag, "_reqWe"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
    mem_ack = 1'b1; mem_rdata = rdata;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk({tag, "_reqDrop"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_fillCH"}, {31'd0, CH}, 32'd1);
    chk({tag, "_fillCD"}, CD, rdata);
  endtask

  task automatic store(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] f3, input logic re);
    @(negedge clk);
    A = addr; WD = wd; funct3 = f3; WE = 1'b1; RE = re;
    #1;
    chk({tag, "_stall0"}, {31'd0, stall}, 32'd1);
    @(negedge clk); #1;
    chk({tag, "_req"}, {31'd0, mem_req}, 32'd1);
    chk({tag, "_we"}, {31'd0, mem_we}, 32'd1);
    chk({tag, "_addr"}, mem_addr, addr);
    chk({tag, "_wd"}, mem_wd, wd);
    chk({tag, "_f3"}, {29'd0, mem_funct3}, {29'd0, f3});
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0; WE = 1'b0; RE = 1'b0;
    #1;
    chk({tag, "_reqDrop"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_stallDrop"}, {31'd0, stall}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; A = '0; WD = '0; WE = 1'b0; RE = 1'b0; funct3 = 3'b010;
    mem_rdata = '0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_CH", {31'd0, CH}, 32'd0);
    rst = 1'b0;

    // First fill with one extra cycle of memory latency.
    @(negedge clk);
    A = 32'h40; funct3 = 3'b010; RE = 1'b1;
    #1;
    chk("f0_CV", {31'd0, CV}, 32'd0);
    chk("f0_CH", {31'd0, CH}, 32'd0);
    chk("f0_stall", {31'd0, stall}, 32'd1);
    chk("f0_req_c0", {31'd0, mem_req}, 32'd0);
    @(negedge clk); #1;
    chk("f0_req", {31'd0, mem_req}, 32'd1);
    chk("f0_we", {31'd0, mem_we}, 32'd0);
    chk("f0_addr", mem_addr, 32'h40);
    chk("f0_f3", {29'd0, mem_funct3}, 32'd2);
    @(negedge clk); #1;
    chk("f0_req_wait", {31'd0, mem_req}, 32'd1);
    chk("f0_stall_wait", {31'd0, stall}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("f0_reqDrop", {31'd0, mem_req}, 32'd0);
    chk("f0_CH", {31'd0, CH}, 32'd1);
    chk("f0_CD", CD, 32'hDEADBEEF);
    chk("f0_stallDrop", {31'd0, stall}, 32'd0);

    // Store hits merge into the line.
    store("sw40", 32'h40, 32'h80FF7F01, 3'b010, 1'b0);
    load_hit("lb41", 32'h41, 3'b000, 32'h0000007F);
    load_hit("lb43", 32'h43, 3'b000, 32'hFFFFFF80);
    load_hit("lhu42", 32'h42, 3'b101, 32'h000080FF);
    load_hit("lh42", 32'h42, 3'b001, 32'hFFFF80FF);
    load_hit("lbu43", 32'h43, 3'b100, 32'h00000080);
    store("sb42", 32'h42, 32'h000000AA, 3'b000, 1'b0);
    load_hit("lw40a", 32'h40, 3'b010, 32'h80AA7F01);

    // Store miss to the same index must not allocate or disturb the line.
    store("sw100", 32'h100, 32'h12345678, 3'b010, 1'b0);
    load_hit("lw40b", 32'h40, 3'b010, 32'h80AA7F01);
    miss_fill("lw100", 32'h100, 32'h01000100);

    // Index aliasing: 0x40, 0x60 and 0x100 all map to set 0.
    miss_fill("lw40c", 32'h40, 32'hCAFE0040);
    miss_fill("lw60", 32'h60, 32'h60606060);

    @(negedge clk);
    A = 32'h60; funct3 = 3'b011; RE = 1'b1;
    #1;
    chk("bad_CD", CD, 32'd0);
    chk("bad_CH", {31'd0, CH}, 32'd0);
    chk("bad_stall", {31'd0, stall}, 32'd0);

    // Reset in the middle of a fill abandons it.
    @(negedge clk);
    A = 32'h40; funct3 = 3'b010; RE = 1'b1;
    #1;
    chk("lw40d_CH", {31'd0, CH}, 32'd0);
    chk("lw40d_stall", {31'd0, stall}, 32'd1);
    @(negedge clk); #1;
    chk("lw40d_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1; RE = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      A = 32'(i * 4);
      #1;
      chk($sformatf("mid_rst_CV%0d", i), {31'd0, CV}, 32'd0);
    end
    A = 32'h40; mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("late_ack_req", {31'd0, mem_req}, 32'd0);
    chk("late_ack_CV", {31'd0, CV}, 32'd0);

    // Simultaneous RE and WE: store path wins, miss does not allocate.
    store("rewe44", 32'h44, 32'h00000005, 3'b010, 1'b1);
    @(negedge clk);
    A = 32'h44; #1;
    chk("rewe_CV", {31'd0, CV}, 32'd0);
    chk("rewe_idle_req", {31'd0, mem_req}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
